// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter that shares one single-port memory between two request channels.
// Each access is serialised through IDLE -> ISSUE -> RESP, with sticky conflict and timeout flags.
module mem_channel_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          ch_oe,
    input  logic [1:0]          ch_we,
    input  logic [2*ADDR_W-1:0] ch_addr,
    input  logic [2*DATA_W-1:0] ch_wdata,
    input  logic [2*SIZE_W-1:0] ch_size,
    output logic [2*DATA_W-1:0] ch_rdata,
    output logic [1:0]          ch_datardy,
    output logic                mem_oe,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [SIZE_W-1:0]   mem_size,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_datardy,
    output logic                busy,
    output logic                err_conflict,
    output logic                err_timeout
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         valid;
    logic               pick;
    logic               grant;
    logic               last_grant;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  rdata_q;
    logic               timed_out;

    // A channel driving oe and we together is malformed and never considered for a grant.
    assign valid = ch_oe ^ ch_we;
    assign pick  = (valid == 2'b11) ? ~last_grant : valid[1];
    assign busy  = (state != IDLE);

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        timed_out  = 1'b0;
        case (state)
            IDLE:    if (|valid) state_next = ISSUE;
            ISSUE: begin
                if (mem_datardy) begin
                    state_next = RESP;
                end else if (cnt == CNT_LAST) begin
                    state_next = RESP;
                    timed_out  = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            rdata_q      <= '0;
            mem_oe       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_size     <= '0;
            err_conflict <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_conflict <= err_conflict | (|(ch_oe & ch_we));
            case (state)
                IDLE: begin
                    if (|valid) begin
                        grant      <= pick;
                        last_grant <= pick;
                        cnt        <= '0;
                        mem_oe     <= ch_oe[pick];
                        mem_we     <= ch_we[pick];
                        mem_addr   <= pick ? ch_addr[2*ADDR_W-1:ADDR_W]   : ch_addr[ADDR_W-1:0];
                        mem_wdata  <= pick ? ch_wdata[2*DATA_W-1:DATA_W] : ch_wdata[DATA_W-1:0];
                        mem_size   <= pick ? ch_size[2*SIZE_W-1:SIZE_W]   : ch_size[SIZE_W-1:0];
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (mem_datardy) begin
                        rdata_q <= mem_oe ? mem_rdata : '0;
                        mem_oe  <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q     <= '0;
                        mem_oe      <= 1'b0;
                        mem_we      <= 1'b0;
                        err_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion is decoded from RESP so it is exactly one cycle wide and only on the granted lane.
    always_comb begin
        ch_datardy = 2'b00;
        ch_rdata   = '0;
        if (state == RESP) begin
            if (grant) begin
                ch_datardy                  = 2'b10;
                ch_rdata[2*DATA_W-1:DATA_W] = rdata_q;
            end else begin
                ch_datardy          = 2'b01;
                ch_rdata[DATA_W-1:0] = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: read, write, timeout, conflict, reset-abort, contention.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_mem_channel_arbiter;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int SIZE_W  = 4;
    localparam int TIMEOUT = 4;

    logic                clock;
    logic                reset;
    logic [1:0]          ch_oe;
    logic [1:0]          ch_we;
    logic [2*ADDR_W-1:0] ch_addr;
    logic [2*DATA_W-1:0] ch_wdata;
    logic [2*SIZE_W-1:0] ch_size;
    logic [2*DATA_W-1:0] ch_rdata;
    logic [1:0]          ch_datardy;
    logic                mem_oe;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [SIZE_W-1:0]   mem_size;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_datardy;
    logic                busy;
    logic                err_conflict;
    logic                err_timeout;

    int tests_run;
    int tests_failed;

    mem_channel_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .ch_oe(ch_oe), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_size(ch_size),
        .ch_rdata(ch_rdata), .ch_datardy(ch_datardy),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_datardy(mem_datardy),
        .busy(busy), .err_conflict(err_conflict), .err_timeout(err_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int oe_cycles;
    int ch0_hits;
    int rd_hits;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset       = 1'b0;
        ch_oe       = 2'b00;
        ch_we       = 2'b00;
        ch_addr     = '0;
        ch_wdata    = '0;
        ch_size     = '0;
        mem_rdata   = '0;
        mem_datardy = 1'b0;

        // Reset state
        tick();
        check("rst_busy",    32'(busy), 32'h0);
        check("rst_mem_oe",  32'(mem_oe), 32'h0);
        check("rst_mem_we",  32'(mem_we), 32'h0);
        check("rst_datardy", 32'(ch_datardy), 32'h0);
        check("rst_errs",    32'({err_conflict, err_timeout}), 32'h0);
        reset = 1'b1;
        tick();

        // Single read on channel 0, memory answers in the second strobe cycle
        ch_oe   = 2'b01;
        ch_addr = {12'h000, 12'h010};
        ch_size = {4'h0, 4'h1};
        tick();
        check("rd_oe1",    32'(mem_oe), 32'h1);
        check("rd_addr",   32'(mem_addr), 32'h010);
        check("rd_busy",   32'(busy), 32'h1);
        check("rd_nordy1", 32'(ch_datardy), 32'h0);
        tick();
        check("rd_oe2",    32'(mem_oe), 32'h1);
        check("rd_nordy2", 32'(ch_datardy), 32'h0);
        mem_datardy = 1'b1;
        mem_rdata   = 8'hA5;
        tick();
        check("rd_oe_drop", 32'(mem_oe), 32'h0);
        check("rd_datardy", 32'(ch_datardy), 32'h1);
        check("rd_rdata",   32'(ch_rdata), 32'h00A5);
        ch_oe       = 2'b00;
        mem_datardy = 1'b0;
        tick();
        check("rd_idle_busy", 32'(busy), 32'h0);
        check("rd_idle_rdy",  32'(ch_datardy), 32'h0);

        // Write on channel 1; channel inputs change mid-access and must not leak through
        ch_we    = 2'b10;
        ch_addr  = {12'h3FF, 12'h000};
        ch_wdata = {8'h5C, 8'h00};
        ch_size  = {4'h8, 4'h0};
        tick();
        check("wr_we",    32'(mem_we), 32'h1);
        check("wr_oe",    32'(mem_oe), 32'h0);
        check("wr_addr",  32'(mem_addr), 32'h3FF);
        check("wr_wdata", 32'(mem_wdata), 32'h5C);
        check("wr_size",  32'(mem_size), 32'h8);
        ch_addr  = {12'h111, 12'h222};
        ch_wdata = {8'h33, 8'h44};
        tick();
        check("wr_addr_hold",  32'(mem_addr), 32'h3FF);
        check("wr_wdata_hold", 32'(mem_wdata), 32'h5C);
        mem_datardy = 1'b1;
        mem_rdata   = 8'hEE;
        tick();
        check("wr_datardy", 32'(ch_datardy), 32'h2);
        check("wr_rdata",   32'(ch_rdata), 32'h0000);
        check("wr_we_drop", 32'(mem_we), 32'h0);
        ch_we       = 2'b00;
        mem_datardy = 1'b0;
        tick();

        // Timeout: memory never answers, strobe lasts exactly TIMEOUT cycles
        ch_oe     = 2'b01;
        ch_addr   = {12'h000, 12'h0AB};
        mem_rdata = 8'h99;
        check("to_err_before", 32'(err_timeout), 32'h0);
        tick();
        oe_cycles = 0;
        for (int i = 0; i < 20 && mem_oe; i++) begin
            oe_cycles++;
            tick();
        end
        check("to_oe_cycles", 32'(oe_cycles), 32'(TIMEOUT));
        check("to_datardy",   32'(ch_datardy), 32'h1);
        check("to_rdata",     32'(ch_rdata), 32'h0);
        check("to_err",       32'(err_timeout), 32'h1);
        ch_oe = 2'b00;
        tick();
        tick();
        check("to_err_sticky", 32'(err_timeout), 32'h1);
        check("to_idle_busy",  32'(busy), 32'h0);

        // Conflict on channel 0 while channel 1 makes a legal read
        check("cf_err_before", 32'(err_conflict), 32'h0);
        ch_oe   = 2'b11;
        ch_we   = 2'b01;
        ch_addr = {12'h123, 12'h456};
        mem_rdata = 8'h3C;
        tick();
        check("cf_err",   32'(err_conflict), 32'h1);
        check("cf_addr",  32'(mem_addr), 32'h123);
        mem_datardy = 1'b1;
        tick();
        check("cf_datardy", 32'(ch_datardy), 32'h2);
        check("cf_rdata",   32'(ch_rdata), 32'h3C00);
        ch_oe       = 2'b01;
        mem_datardy = 1'b0;
        ch0_hits    = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ch_datardy[0] || busy) ch0_hits++;
        end
        check("cf_ch0_never", 32'(ch0_hits), 32'h0);
        check("cf_err_sticky", 32'(err_conflict), 32'h1);
        ch_oe = 2'b00;
        ch_we = 2'b00;
        tick();

        // Reset during ISSUE, last grant was channel 1 so without reset channel 0 would win anyway;
        // make channel 0 the last grant first so the reset value of last_grant is what matters.
        ch_oe   = 2'b01;
        ch_addr = {12'h0C1, 12'h0C0};
        tick();
        mem_datardy = 1'b1;
        tick();
        ch_oe       = 2'b00;
        mem_datardy = 1'b0;
        tick();
        ch_oe = 2'b01;
        tick();
        check("ri_oe_before", 32'(mem_oe), 32'h1);
        reset = 1'b0;
        #1;
        check("ri_oe_async",   32'(mem_oe), 32'h0);
        check("ri_busy_async", 32'(busy), 32'h0);
        check("ri_errs_clr",   32'({err_conflict, err_timeout}), 32'h0);
        ch_oe       = 2'b11;
        mem_datardy = 1'b1;
        mem_rdata   = 8'h77;
        rd_hits     = 0;
        tick();
        if (ch_datardy != 2'b00) rd_hits++;
        check("ri_no_datardy", 32'(rd_hits), 32'h0);
        reset = 1'b1;

        // Contention from reset release, memory latency 1: grants alternate 0,1,0,1
        for (int g = 0; g < 4; g++) begin
            tick();
            check($sformatf("ct%0d_addr", g), 32'(mem_addr), (g % 2 == 0) ? 32'h0C0 : 32'h0C1);
            check($sformatf("ct%0d_busy", g), 32'(busy), 32'h1);
            tick();
            check($sformatf("ct%0d_rdy", g), 32'(ch_datardy), (g % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("ct%0d_rdata", g), 32'(ch_rdata), (g % 2 == 0) ? 32'h0077 : 32'h7700);
            tick();
            check($sformatf("ct%0d_bubble", g), 32'({busy, ch_datardy}), 32'h0);
        end
        ch_oe       = 2'b00;
        mem_datardy = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
Shares one single-port external memory between the two master channels of a generated accelerator top. Each channel uses the oe/we/addr/wdata/size request, rdata/DataRdy response protocol. The block arbitrates round-robin, serialises accesses onto the memory port, returns read data to the granted channel and flags protocol errors and stalled memory accesses. It sits between the accelerator's Mout_* bus and the off-chip memory model or controller.

Parameters:
ADDR_W, 12, per-channel address width
DATA_W, 8, per-channel data width
SIZE_W, 4, per-channel access-size field width
TIMEOUT, 255, max cycles waiting for mem_datardy before abort (1..65535)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
ch_oe  in  2  per-channel read request, held until ch_datardy
ch_we  in  2  per-channel write request, held until ch_datardy
ch_addr  in  2*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  2*DATA_W  write data, same packing
ch_size  in  2*SIZE_W  access size, same packing
ch_rdata  out  2*DATA_W  read data, valid only while matching ch_datardy bit is 1
ch_datardy  out  2  one-cycle completion pulse per channel
mem_oe  out  1  memory read strobe, held until mem_datardy
mem_we  out  1  memory write strobe, held until mem_datardy
mem_addr  out  ADDR_W  registered address of granted request
mem_wdata  out  DATA_W  registered write data
mem_size  out  SIZE_W  registered size
mem_rdata  in  DATA_W  read data, sampled when mem_datardy=1
mem_datardy  in  1  memory completion, one cycle
busy  out  1  1 in any state other than IDLE
err_conflict  out  1  sticky: a channel asserted oe and we together
err_timeout  out  1  sticky: an access hit TIMEOUT

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0. last_grant=1, so channel 0 wins the first contention. Timeout counter cleared. A reset mid-access drops mem_oe/mem_we immediately; no ch_datardy is produced for the aborted access.
- FSM states are IDLE, ISSUE, RESP.
- IDLE: valid request on channel i means exactly one of ch_oe[i]/ch_we[i] is 1.
  - If one channel is valid, grant it.
  - If both are valid, grant the channel != last_grant.
  - Capture addr/wdata/size/op into the mem_* registers, set last_grant, go to ISSUE.
  - If neither channel is valid, stay in IDLE.
- ISSUE: mem_oe or mem_we is held at 1 with stable mem_addr/mem_wdata/mem_size.
  - The counter increments each cycle.
  - On mem_datardy=1: capture mem_rdata (or 0 for a write), drop the strobes at the next edge, go to RESP.
  - If the counter reaches TIMEOUT without mem_datardy: drop the strobes, set rdata=0, set err_timeout, go to RESP.
  - mem_datardy seen in the same cycle the counter reaches TIMEOUT counts as success.
- RESP: ch_datardy[grant]=1 for exactly one cycle, with ch_rdata[grant] holding the captured data. Other channel outputs stay 0. Then go to IDLE.
  - The cycle back to IDLE is a mandatory bubble, so a requester that is still held at the RESP edge is not re-served.
- Latency: request first visible in IDLE at cycle t gives mem strobe at t+1. mem_datardy at cycle k gives ch_datardy at k+1. Minimum request-to-completion is 3 cycles.
- Conflict: oe and we both 1 on a channel makes it invalid; it is never granted. err_conflict is set on the next edge. The other channel is still served normally.
- mem_datardy while in IDLE or RESP is ignored.
- Request changes on a channel while its access is in ISSUE are ignored, because the mem_* outputs are registered copies.
- err_conflict and err_timeout clear only on reset.
- Round-robin fairness: with both channels continuously requesting, grants alternate 0,1,0,1.

Test Plan:
- Single read: ch_oe=01, addr0=0x010; memory asserts mem_datardy 2 cycles after mem_oe with mem_rdata=0xA5 -> mem_oe for 2 cycles, ch_datardy=01 pulse one cycle later with ch_rdata[7:0]=0xA5, busy low afterwards.
- Contention: ch_oe=11 held from reset release, memory latency 1 -> grants alternate ch0, ch1, ch0, ch1 and each ch_datardy bit pulses every 3rd cycle alternately.
- Write: ch_we=10, addr1=0x3FF, wdata1=0x5C, size1=8 -> mem_we=1, mem_addr=0x3FF, mem_wdata=0x5C, mem_size=8 until mem_datardy, then ch_datardy=10 with ch_rdata[15:8]=0.
- Timeout: TIMEOUT=4, ch_oe=01, mem_datardy never asserts -> mem_oe high exactly 4 cycles, then ch_datardy=01 with rdata 0, err_timeout=1 and stays 1.
- Conflict: ch_oe=01 and ch_we=01 together, ch_oe[1]=1 -> err_conflict=1, only channel 1 is served, channel 0 never receives ch_datardy.
- Reset in ISSUE: assert reset low for 1 cycle while mem_oe=1 -> mem_oe and busy 0 immediately, no ch_datardy, next contention grants channel 0 first.
